// File: rtl/tdm_demux.sv
// Receive-side TDM framer: locks onto the slot-0 sync marker and rebuilds
// each frame of CHANNELS samples into one parallel word with a valid pulse.

module tdm_demux_lane #(
    parameter int WIDTH   = 8,
    parameter bit IS_LAST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic             cap_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] out_o
);
    logic [WIDTH-1:0] out_q;

    generate
        if (IS_LAST) begin : g_last
            // The last slot completes the frame, so it goes straight to the output.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        out_q <= '0;
                else if (cap_i) out_q <= din_i;
            end
        end else begin : g_mid
            logic [WIDTH-1:0] buf_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    buf_q <= '0;
                    out_q <= '0;
                end else begin
                    if (wr_i)  buf_q <= din_i;
                    if (cap_i) out_q <= buf_q;
                end
            end
        end
    endgenerate

    assign out_o = out_q;
endmodule

module tdm_demux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SW       = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_sync,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_valid,
    output logic                      locked,
    output logic                      sync_err,
    output logic [SW-1:0]             slot
);
    typedef enum logic {HUNT, LOCKED} state_t;

    state_t        state_q;
    logic [SW-1:0] slot_q;
    logic          out_valid_q;
    logic          sync_err_q;

    logic [CHANNELS-1:0]            wr;
    logic                           cap;
    logic                           last_slot;
    logic [CHANNELS-1:0][WIDTH-1:0] lane_out;

    assign last_slot = (slot_q == SW'(CHANNELS - 1));

    always_comb begin
        wr  = '0;
        cap = 1'b0;
        if (in_valid) begin
            if (in_sync) begin
                wr[0] = 1'b1;
            end else if (state_q == LOCKED && slot_q != '0) begin
                wr[slot_q] = 1'b1;
                cap        = last_slot;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            out_valid_q <= cap;
            sync_err_q  <= 1'b0;
            if (in_valid) begin
                case (state_q)
                    HUNT: begin
                        if (in_sync) begin
                            slot_q  <= SW'(1);
                            state_q <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (in_sync) begin
                            // Early sync abandons the partial frame and restarts at slot 1.
                            sync_err_q <= (slot_q != '0);
                            slot_q     <= SW'(1);
                        end else if (slot_q == '0) begin
                            sync_err_q <= 1'b1;
                            state_q    <= HUNT;
                        end else if (last_slot) begin
                            slot_q <= '0;
                        end else begin
                            slot_q <= slot_q + SW'(1);
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < CHANNELS; k++) begin : g_lane
            tdm_demux_lane #(
                .WIDTH  (WIDTH),
                .IS_LAST(k == CHANNELS - 1)
            ) u_lane (
                .clk  (clk),
                .rst  (rst),
                .wr_i (wr[k]),
                .cap_i(cap),
                .din_i(in_data),
                .out_o(lane_out[k])
            );
        end
    endgenerate

    assign out_data  = lane_out;
    assign out_valid = out_valid_q;
    assign locked    = (state_q == LOCKED);
    assign sync_err  = sync_err_q;
    assign slot      = slot_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: expected frames are queued as beats are
// driven and checked by a monitor whenever out_valid fires.

module tb_tdm_demux;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int SW       = $clog2(CHANNELS);

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      in_valid = 1'b0;
    logic [WIDTH-1:0]          in_data = '0;
    logic                      in_sync = 1'b0;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic                      out_valid;
    logic                      locked;
    logic                      sync_err;
    logic [SW-1:0]             slot;

    int checks = 0;
    int errors = 0;

    logic [CHANNELS*WIDTH-1:0] exp_q[$];
    int  ov_cnt = 0;
    int  se_cnt = 0;
    int  cycle = 0;
    int  last_ov = -1;
    bit  b2b_mode = 1'b0;

    tdm_demux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_sync  (in_sync),
        .out_data (out_data),
        .out_valid(out_valid),
        .locked   (locked),
        .sync_err (sync_err),
        .slot     (slot)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: pops the scoreboard on every out_valid.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && sync_err) begin
                checks++; errors++;
                $display("FAIL overlap: out_valid and sync_err both high at cycle %0d", cycle);
            end
            if (sync_err) se_cnt++;
            if (out_valid) begin
                ov_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame: got %h, scoreboard empty", out_data);
                end else begin
                    logic [CHANNELS*WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL frame_data: got %h expected %h", out_data, e);
                    end
                end
                if (b2b_mode && last_ov >= 0) begin
                    checks++;
                    if (cycle - last_ov != CHANNELS) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d cycles expected %0d", cycle - last_ov, CHANNELS);
                    end
                end
                last_ov = cycle;
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] d, input logic s);
        in_valid = 1'b1; in_data = d; in_sync = s;
        @(negedge clk);
        in_valid = 1'b0; in_sync = 1'b0; in_data = 'x;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_sync = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_data !== '0 || out_valid !== 1'b0 || locked !== 1'b0 || sync_err !== 1'b0 || slot !== '0) begin
            errors++;
            $display("FAIL reset_state: data=%h ov=%b lk=%b se=%b slot=%0d expected all zero",
                     out_data, out_valid, locked, sync_err, slot);
        end
    endtask

    task automatic test_clean_frames();
        int ov0, se0;
        ov0 = ov_cnt; se0 = se_cnt;
        send(8'h11, 1'b1);
        checks++;
        if (locked !== 1'b1 || slot !== SW'(1)) begin
            errors++;
            $display("FAIL clean_lock: locked=%b slot=%0d expected 1/1", locked, slot);
        end
        send(8'h22, 1'b0); send(8'h33, 1'b0);
        exp_q.push_back(32'h44332211);
        send(8'h44, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h44332211) begin
            errors++;
            $display("FAIL clean_latency: ov=%b data=%h expected 1/44332211", out_valid, out_data);
        end
        send(8'h55, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL clean_pulse: ov=%b locked=%b expected 0/1", out_valid, locked);
        end
        send(8'h66, 1'b0); send(8'h77, 1'b0);
        exp_q.push_back(32'h88776655);
        send(8'h88, 1'b0);
        idle(2);
        checks++;
        if (ov_cnt - ov0 != 2 || se_cnt != se0 || locked !== 1'b1 || out_data !== 32'h88776655) begin
            errors++;
            $display("FAIL clean_frames: frames=%0d errs=%0d locked=%b data=%h expected 2/0/1/88776655",
                     ov_cnt - ov0, se_cnt - se0, locked, out_data);
        end
    endtask

    task automatic test_reset_midframe();
        send(8'hEE, 1'b1);
        send(8'hEF, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_data !== '0 || out_valid !== 1'b0 || locked !== 1'b0 || sync_err !== 1'b0 || slot !== '0) begin
            errors++;
            $display("FAIL reset_async: data=%h ov=%b lk=%b se=%b slot=%0d expected all zero",
                     out_data, out_valid, locked, sync_err, slot);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_hunt_stalls();
        int ov0, se0;
        logic [WIDTH-1:0] d[4];
        d[0] = 8'h01; d[1] = 8'h02; d[2] = 8'h03; d[3] = 8'h04;
        ov0 = ov_cnt; se0 = se_cnt;
        send(8'hA0, 1'b0); idle(1); send(8'hA1, 1'b0);
        checks++;
        if (locked !== 1'b0 || slot !== '0 || se_cnt != se0) begin
            errors++;
            $display("FAIL hunt_drop: locked=%b slot=%0d errs=%0d expected 0/0/0", locked, slot, se_cnt - se0);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(32'h04030201);
            send(d[i], i == 0);
            idle(i % 4);
        end
        idle(2);
        checks++;
        if (ov_cnt - ov0 != 1 || se_cnt != se0 || out_data !== 32'h04030201) begin
            errors++;
            $display("FAIL hunt_frame: frames=%0d errs=%0d data=%h expected 1/0/04030201",
                     ov_cnt - ov0, se_cnt - se0, out_data);
        end
    endtask

    task automatic test_early_sync();
        int ov0, se0;
        logic [CHANNELS*WIDTH-1:0] prev;
        do_reset();
        ov0 = ov_cnt; se0 = se_cnt; prev = out_data;
        send(8'h10, 1'b1); send(8'h20, 1'b0);
        send(8'h30, 1'b1);
        checks++;
        if (sync_err !== 1'b1 || out_valid !== 1'b0 || slot !== SW'(1) || locked !== 1'b1 || out_data !== prev) begin
            errors++;
            $display("FAIL early_sync_err: se=%b ov=%b slot=%0d lk=%b data=%h expected 1/0/1/1/%h",
                     sync_err, out_valid, slot, locked, out_data, prev);
        end
        send(8'h40, 1'b0);
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL early_sync_pulse: se=%b expected 0", sync_err);
        end
        send(8'h50, 1'b0);
        exp_q.push_back(32'h60504030);
        send(8'h60, 1'b0);
        idle(2);
        checks++;
        if (ov_cnt - ov0 != 1 || se_cnt - se0 != 1 || out_data !== 32'h60504030) begin
            errors++;
            $display("FAIL early_sync_frame: frames=%0d errs=%0d data=%h expected 1/1/60504030",
                     ov_cnt - ov0, se_cnt - se0, out_data);
        end
    endtask

    task automatic test_missing_sync();
        int ov0, se0;
        ov0 = ov_cnt; se0 = se_cnt;
        send(8'hB1, 1'b1); send(8'hB2, 1'b0); send(8'hB3, 1'b0);
        exp_q.push_back(32'hB4B3B2B1);
        send(8'hB4, 1'b0);
        send(8'h99, 1'b0);
        checks++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || slot !== '0 || out_data !== 32'hB4B3B2B1) begin
            errors++;
            $display("FAIL missing_sync: se=%b lk=%b slot=%0d data=%h expected 1/0/0/b4b3b2b1",
                     sync_err, locked, slot, out_data);
        end
        idle(1);
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL missing_sync_pulse: se=%b expected 0", sync_err);
        end
        send(8'hC1, 1'b1); send(8'hC2, 1'b0); send(8'hC3, 1'b0);
        exp_q.push_back(32'hC4C3C2C1);
        send(8'hC4, 1'b0);
        idle(2);
        checks++;
        if (ov_cnt - ov0 != 2 || se_cnt - se0 != 1 || locked !== 1'b1 || out_data !== 32'hC4C3C2C1) begin
            errors++;
            $display("FAIL relock: frames=%0d errs=%0d lk=%b data=%h expected 2/1/1/c4c3c2c1",
                     ov_cnt - ov0, se_cnt - se0, locked, out_data);
        end
    endtask

    task automatic test_back_to_back();
        int ov0, se0;
        logic [CHANNELS*WIDTH-1:0] w;
        do_reset();
        ov0 = ov_cnt; se0 = se_cnt;
        last_ov = -1; b2b_mode = 1'b1;
        for (int f = 0; f < 100; f++) begin
            w = {$urandom, $urandom};
            exp_q.push_back(w);
            for (int b = 0; b < CHANNELS; b++) begin
                in_valid = 1'b1; in_sync = (b == 0); in_data = w[b*WIDTH +: WIDTH];
                @(negedge clk);
            end
        end
        idle(3);
        b2b_mode = 1'b0;
        checks++;
        if (ov_cnt - ov0 != 100 || se_cnt != se0) begin
            errors++;
            $display("FAIL back_to_back: frames=%0d errs=%0d expected 100/0", ov_cnt - ov0, se_cnt - se0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_frames();
        test_reset_midframe();
        test_hunt_stalls();
        test_early_sync();
        test_missing_sync();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d frames left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
